// File: rtl/chunked_adder_subtractor.sv
// ---------------------------------------------------------------------------
// chunked_adder_subtractor
//
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operation is
// processed CHUNK bits per clock, least-significant chunk first, with the
// inter-chunk carry held in a register. Results and flags appear together on
// completion and hold until the next completion.
//
// Parameters:
//   WIDTH    operand/result width; must be a multiple of CHUNK
//   CHUNK    bits processed per clock, 1 <= CHUNK <= WIDTH
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   start     in   operation request, accepted only while ready=1
//   sub       in   0: a+b, 1: a-b (sampled with start)
//   a, b      in   WIDTH-bit two's-complement operands (sampled with start)
//   ready     out  idle and able to accept start
//   done      out  one-cycle pulse when sum/flags update
//   sum       out  result modulo 2^WIDTH
//   carryout  out  carry out of the MSB (subtract: 1 means no borrow)
//   overflow  out  signed overflow
//   zero      out  sum == 0
// ---------------------------------------------------------------------------
module chunked_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("chunked_adder_subtractor: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      w_accept;
  logic                      w_last;

  // Operand registers; r_b already holds the inverted operand in subtract mode
  logic signed [WIDTH-1:0]   r_a;
  logic signed [WIDTH-1:0]   r_b;
  logic                      r_carry;
  logic        [IDX_W-1:0]   r_idx;
  logic        [WIDTH-1:0]   r_work;

  logic        [WIDTH-1:0]   r_sum;
  logic                      r_carryout;
  logic                      r_overflow;
  logic                      r_zero;
  logic                      r_done;

  logic        [BASE_W-1:0]  w_base;
  logic        [CHUNK:0]     w_chunk_res;
  logic        [WIDTH-1:0]   w_work_next;
  logic                      w_overflow;

  // One chunk of the ripple: CHUNK-bit sum plus carry out in the top bit.
  function automatic logic [CHUNK:0] add_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             cin
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  endfunction

  // Bit position of the chunk currently being processed
  assign w_base = BASE_W'(32'(r_idx) * 32'(CHUNK));

  assign w_chunk_res = add_chunk(r_a[w_base +: CHUNK], r_b[w_base +: CHUNK], r_carry);

  // Full-width view of the sum including the chunk produced this cycle; on
  // the last chunk this is the final result.
  always_comb begin
    w_work_next = r_work;
    w_work_next[w_base +: CHUNK] = w_chunk_res[CHUNK-1:0];
  end

  // Signed overflow judged against the post-inversion second operand
  assign w_overflow = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_work_next[WIDTH-1] != r_a[WIDTH-1]);

  assign w_last = (r_state == S_RUN) && (r_idx == LAST_IDX);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_accept     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand capture and chunk-serial accumulation
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_work  <= '0;
    end else if (w_accept) begin
      // Subtraction as a + ~b + 1: invert b here and seed the carry with sub
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= sub;
      r_idx   <= '0;
      r_work  <= '0;
    end else if (r_state == S_RUN) begin
      r_work  <= w_work_next;
      r_carry <= w_chunk_res[CHUNK];
      r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Result registers: updated only on the final chunk so partial sums never
  // reach the outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum      <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_sum      <= w_work_next;
        r_carryout <= w_chunk_res[CHUNK];
        r_overflow <= w_overflow;
        r_zero     <= (w_work_next == '0);
      end
    end
  end

  // ready is high the cycle done pulses, allowing back-to-back operations
  assign ready    = (r_state == S_IDLE);
  assign done     = r_done;
  assign sum      = r_sum;
  assign carryout = r_carryout;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule

// File: tb/tb_chunked_adder_subtractor.sv
// ---------------------------------------------------------------------------
// tb_chunked_adder_subtractor
//
// Three DUT instances (16/4, 8/8, 8/1) run in parallel. For each, a driver
// issues directed and random operations, a reference model predicts the
// handshake and pushes expected results into a queue on acceptance, and a
// monitor compares every cycle: ready/done against the model, and sum/flags
// against the popped result on done or the held result otherwise.
// ---------------------------------------------------------------------------
module tb_chunked_adder_subtractor;

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input int cfg, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s: actual=%0h required=%0h at %0t", cfg, nm, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: unsigned and signed integer results.
  function automatic res_t ref_op(input int w, input logic [15:0] ia,
                                  input logic [15:0] ib, input logic is);
    longint m, ua, ub, sa, sb, ur, sr;
    res_t   r;
    m  = longint'(1) << w;
    ua = longint'(ia) & (m - 1);
    ub = longint'(ib) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (is) begin
      ur   = ua - ub;
      sr   = sa - sb;
      r.co = (ua >= ub);
    end else begin
      ur   = ua + ub;
      sr   = sa + sb;
      r.co = (ur >= m);
    end
    ur    = ((ur % m) + m) % m;
    r.sum = 16'(ur);
    r.ov  = (sr >= m / 2) || (sr < -(m / 2));
    r.z   = (ur == 0);
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = (g == 0) ? 16 : 8;
    localparam int C = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
    localparam int N = W / C;
    localparam int RST_EDGES = (N >= 2) ? 1 : 0;

    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         ready, done, carryout, overflow, zero;
    logic [W-1:0] sum;

    res_t q[$];
    int   m_busy = 0;
    bit   m_done = 1'b0;
    bit   fin    = 1'b0;

    chunked_adder_subtractor #(.WIDTH(W), .CHUNK(C)) dut (
      .clk      (clk),
      .reset    (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .done     (done),
      .sum      (sum),
      .carryout (carryout),
      .overflow (overflow),
      .zero     (zero)
    );

    // Handshake model: idle accepts start, then busy for N edges.
    initial begin
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          m_busy = 0;
          m_done = 1'b0;
          q.delete();
        end else begin
          m_done = 1'b0;
          if (m_busy == 0) begin
            if (start) begin
              q.push_back(ref_op(W, 16'(a), 16'(b), sub));
              m_busy = N;
            end
          end else begin
            m_busy--;
            if (m_busy == 0) m_done = 1'b1;
          end
        end
      end
    end

    // Monitor
    initial begin
      res_t last;
      res_t e;
      last = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          last = '0;
          chk(g, "rst_ready", 32'(ready), 32'd1);
          chk(g, "rst_done", 32'(done), 32'd0);
          chk(g, "rst_sum", 32'(sum), 32'd0);
          chk(g, "rst_carryout", 32'(carryout), 32'd0);
          chk(g, "rst_overflow", 32'(overflow), 32'd0);
          chk(g, "rst_zero", 32'(zero), 32'd0);
        end else begin
          chk(g, "ready", 32'(ready), 32'(m_busy == 0));
          chk(g, "done", 32'(done), 32'(m_done));
          if (done) begin
            chk(g, "sb_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
              e    = q.pop_front();
              last = e;
            end
          end
          chk(g, "sum", 32'(sum), 32'(last.sum[W-1:0]));
          chk(g, "carryout", 32'(carryout), 32'(last.co));
          chk(g, "overflow", 32'(overflow), 32'(last.ov));
          chk(g, "zero", 32'(zero), 32'(last.z));
        end
      end
    end

    // Caller is 1 time unit after a rising edge; start is accepted at the next edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic is);
      start = 1'b1;
      a     = ia[W-1:0];
      b     = ib[W-1:0];
      sub   = is;
      @(posedge clk);
      #1;
      start = 1'b0;
    endtask

    // Advance to the cycle in which done is high.
    task automatic wait_done();
      repeat (N) @(posedge clk);
      #1;
    endtask

    // Driver
    initial begin
      logic [15:0] maxpos, allones, minneg;
      maxpos  = 16'((1 << (W - 1)) - 1);
      allones = 16'((1 << W) - 1);
      minneg  = 16'(1 << (W - 1));

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Directed cases
      issue(maxpos, 16'h0001, 1'b0);  wait_done();
      issue(allones, 16'h0001, 1'b0); wait_done();
      issue(16'h0005, 16'h0005, 1'b1); wait_done();
      issue(minneg, 16'h0001, 1'b1);  wait_done();
      issue(16'h00FF, 16'h0001, 1'b1); wait_done();

      // Starts while busy are ignored; start held in done cycle is taken
      issue(16'h1234, 16'h0F0F, 1'b0);
      for (int i = 1; i < N; i++) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      issue(16'h4321, 16'h1111, 1'b1);
      wait_done();

      // Reset asserted mid-cycle while RUN is in progress
      issue(16'h5555, 16'h2222, 1'b0);
      repeat (RST_EDGES) @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue(16'h1234, 16'h1111, 1'b0);
      wait_done();

      // Random sweep with stray starts during RUN and random gaps
      for (int it = 0; it < 150; it++) begin
        issue(16'($urandom), 16'($urandom), 1'($urandom));
        for (int i = 1; i < N; i++) begin
          start = 1'($urandom);
          a     = W'($urandom);
          b     = W'($urandom);
          sub   = 1'($urandom);
          @(posedge clk);
          #1;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end

      repeat (4) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && cyc < 40000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
      $display("FAIL timeout: sequences unfinished after %0d cycles", cyc);
      $fatal(1, "bench did not complete");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chunked_adder_subtractor.md
Name: chunked_adder_subtractor

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor. Processes a WIDTH-bit operation CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks.
- Successor to the 4-bit combinational ripple adder. Adds width and chunk parametrisation, a subtract mode, zero/overflow flags and a start/done handshake.
- Sits between the ALU control FSM and the result register.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK, the number of processing cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only while ready=1.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  first operand, two's complement; sampled with start.
- b  input  WIDTH  second operand, two's complement; sampled with start.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse when results become valid.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carryout  output  1  carry out of the MSB; in subtract mode 1 means no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: ready=1, done=0, sum=0, carryout=0, overflow=0, zero=0. The FSM goes to IDLE, and the internal chunk index, carry and operand registers clear.
- FSM states: IDLE and RUN.
- IDLE -> RUN on start=1 at a clock edge. At that edge:
  - latch a into A_r;
  - latch b XOR {WIDTH{sub}} into B_r;
  - set the carry register to sub;
  - set the chunk index to 0;
  - set ready=0.
- RUN, each cycle:
  - add chunk[idx] of A_r, chunk[idx] of B_r and the carry register;
  - write the CHUNK-bit result into sum-work bits [idx*CHUNK +: CHUNK];
  - update the carry register;
  - increment idx.
- RUN -> IDLE on the cycle that processes idx = NCHUNK-1. At that edge:
  - sum, carryout, overflow and zero update together;
  - done=1 for exactly one cycle;
  - ready returns to 1.
- Latency: with start accepted at edge 0, done is high after edge NCHUNK. With defaults, done is high in the 4th cycle after the start edge.
- Throughput: start may be asserted in the same cycle that done is high. ready is already 1, so the next operation is accepted at that edge with no idle bubble.
- The sum output changes only at completion. sum and the flags hold their last result through IDLE and RUN until the next completion; partial chunks are never visible.
- overflow = (A_r[MSB] == B_r[MSB]) AND (sum[MSB] != A_r[MSB]). B_r is the post-inversion operand.
- zero is computed from the final full-width sum.
- start while ready=0 is ignored: no queueing, and in-flight operands are unaffected. sub, a and b are don't-care except at the accepting edge.
- Reset asserted mid-RUN aborts the operation immediately, without waiting for a clock edge. All outputs take their reset values and no done pulse is issued.
- CHUNK == WIDTH is legal: single-cycle RUN, with done one cycle after start.

Test Plan:
- Defaults, a=0x7FFF, b=0x0001, sub=0 -> after 4 cycles done=1: sum=0x8000, overflow=1, carryout=0, zero=0. ready is low for exactly 4 cycles.
- a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carryout=1, overflow=0, zero=1.
- a=0x0005, b=0x0005, sub=1 -> sum=0x0000, carryout=1, zero=1, overflow=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, overflow=1, carryout=1.
- Start accepted, then start pulsed with new operands on cycles 1–3 -> these starts are ignored and the result equals the first operation's. Start held high in the done cycle -> the second result arrives exactly 4 cycles later.
- Reset asserted mid-clock in the 2nd RUN cycle -> outputs clear immediately, no done pulse, ready=1 after release. A fresh 0x1234+0x1111 then gives 0x2345.
- WIDTH=8, CHUNK=8 and WIDTH=8, CHUNK=1 on 0x7F+0x01 -> sum=0x80, overflow=1, with latency 1 and 8 cycles respectively.
- Randomized sweep against a reference model for all three parameter sets.
